// File: rtl/id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_exe_stage_reg
//  Description : ID/EXE pipeline register with stall hold, flush bubble and
//                a saturating consecutive-stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_exe_stage_reg #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [WORD_WIDTH-1:0] pc_in,
    input  logic [WORD_WIDTH-1:0] val_rn_in,
    input  logic [WORD_WIDTH-1:0] val_rm_in,
    input  logic [11:0]           shift_operand_in,
    input  logic                  imm_in,
    input  logic [23:0]           signed_imm_in,
    input  logic [3:0]            dest_in,
    input  logic [3:0]            src1_in,
    input  logic [3:0]            src2_in,
    input  logic [3:0]            exe_cmd_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  wb_en_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  logic [3:0]            status_in,
    output logic                  valid_out,
    output logic [WORD_WIDTH-1:0] pc_out,
    output logic [WORD_WIDTH-1:0] val_rn_out,
    output logic [WORD_WIDTH-1:0] val_rm_out,
    output logic [11:0]           shift_operand_out,
    output logic                  imm_out,
    output logic [23:0]           signed_imm_out,
    output logic [3:0]            dest_out,
    output logic [3:0]            src1_out,
    output logic [3:0]            src2_out,
    output logic [3:0]            exe_cmd_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic                  wb_en_out,
    output logic                  b_out,
    output logic                  s_out,
    output logic [3:0]            status_out,
    output logic [7:0]            stall_cnt
);

    localparam logic [7:0] C_STALL_MAX = 8'd255;

    typedef struct packed {
        logic                  valid;
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] val_rn;
        logic [WORD_WIDTH-1:0] val_rm;
        logic [11:0]           shift_operand;
        logic                  imm;
        logic [23:0]           signed_imm;
        logic [3:0]            dest;
        logic [3:0]            src1;
        logic [3:0]            src2;
        logic [3:0]            exe_cmd;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic                  wb_en;
        logic                  b;
        logic                  s;
        logic [3:0]            status;
    } stage_t;

    stage_t     w_in;
    stage_t     stage_d;
    stage_t     stage_q;
    logic       w_bubble;
    logic [7:0] stall_cnt_d;
    logic [7:0] stall_cnt_q;

    always_comb begin
        w_in.valid         = valid_in;
        w_in.pc            = pc_in;
        w_in.val_rn        = val_rn_in;
        w_in.val_rm        = val_rm_in;
        w_in.shift_operand = shift_operand_in;
        w_in.imm           = imm_in;
        w_in.signed_imm    = signed_imm_in;
        w_in.dest          = dest_in;
        w_in.src1          = src1_in;
        w_in.src2          = src2_in;
        w_in.exe_cmd       = exe_cmd_in;
        w_in.mem_r_en      = mem_r_en_in;
        w_in.mem_w_en      = mem_w_en_in;
        w_in.wb_en         = wb_en_in;
        w_in.b             = b_in;
        w_in.s             = s_in;
        w_in.status        = status_in;
    end

    // A simultaneous read+write request is illegal and is squashed like an
    // invalid slot: data still travels, but nothing downstream is enabled.
    assign w_bubble = ~valid_in | (mem_r_en_in & mem_w_en_in);

    always_comb begin
        stage_d     = stage_q;
        stall_cnt_d = 8'd0;
        if (flush) begin
            stage_d = '0;
        end else if (freeze) begin
            stall_cnt_d = (stall_cnt_q == C_STALL_MAX) ? C_STALL_MAX
                                                       : stall_cnt_q + 8'd1;
        end else begin
            stage_d = w_in;
            if (w_bubble) begin
                stage_d.valid    = 1'b0;
                stage_d.mem_r_en = 1'b0;
                stage_d.mem_w_en = 1'b0;
                stage_d.wb_en    = 1'b0;
                stage_d.b        = 1'b0;
                stage_d.s        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q     <= '0;
            stall_cnt_q <= 8'd0;
        end else begin
            stage_q     <= stage_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign valid_out         = stage_q.valid;
    assign pc_out            = stage_q.pc;
    assign val_rn_out        = stage_q.val_rn;
    assign val_rm_out        = stage_q.val_rm;
    assign shift_operand_out = stage_q.shift_operand;
    assign imm_out           = stage_q.imm;
    assign signed_imm_out    = stage_q.signed_imm;
    assign dest_out          = stage_q.dest;
    assign src1_out          = stage_q.src1;
    assign src2_out          = stage_q.src2;
    assign exe_cmd_out       = stage_q.exe_cmd;
    assign mem_r_en_out      = stage_q.mem_r_en;
    assign mem_w_en_out      = stage_q.mem_w_en;
    assign wb_en_out         = stage_q.wb_en;
    assign b_out             = stage_q.b;
    assign s_out             = stage_q.s;
    assign status_out        = stage_q.status;
    assign stall_cnt         = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_exe_stage_reg
//  Description : Scoreboard bench for the ID/EXE stage register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_exe_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [11:0] shift_operand;
        logic        imm;
        logic [23:0] signed_imm;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  exe_cmd;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        wb_en;
        logic        b;
        logic        s;
        logic [3:0]  status;
    } stage_t;

    typedef struct packed {
        stage_t     st;
        logic [7:0] cnt;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst, freeze, flush;
    stage_t din;
    stage_t dout;
    logic [7:0] stall_cnt;

    exp_t   sb_q[$];
    stage_t m_st;
    logic [7:0] m_cnt;
    int     checks = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    id_exe_stage_reg #(.WORD_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .valid_in(din.valid), .pc_in(din.pc), .val_rn_in(din.val_rn),
        .val_rm_in(din.val_rm), .shift_operand_in(din.shift_operand),
        .imm_in(din.imm), .signed_imm_in(din.signed_imm), .dest_in(din.dest),
        .src1_in(din.src1), .src2_in(din.src2), .exe_cmd_in(din.exe_cmd),
        .mem_r_en_in(din.mem_r_en), .mem_w_en_in(din.mem_w_en),
        .wb_en_in(din.wb_en), .b_in(din.b), .s_in(din.s), .status_in(din.status),
        .valid_out(dout.valid), .pc_out(dout.pc), .val_rn_out(dout.val_rn),
        .val_rm_out(dout.val_rm), .shift_operand_out(dout.shift_operand),
        .imm_out(dout.imm), .signed_imm_out(dout.signed_imm), .dest_out(dout.dest),
        .src1_out(dout.src1), .src2_out(dout.src2), .exe_cmd_out(dout.exe_cmd),
        .mem_r_en_out(dout.mem_r_en), .mem_w_en_out(dout.mem_w_en),
        .wb_en_out(dout.wb_en), .b_out(dout.b), .s_out(dout.s),
        .status_out(dout.status), .stall_cnt(stall_cnt)
    );

    // Monitor: every rising edge yields one output state to score.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (dout !== e.st) begin
                failures++;
                $display("FAIL stage t=%0t got=%h exp=%h", $time, dout, e.st);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                failures++;
                $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, e.cnt);
            end
            checks++;
            if (dout.mem_r_en && dout.mem_w_en) begin
                failures++;
                $display("FAIL mem_excl t=%0t got=11 exp=not both", $time);
            end
        end
    end

    // Reference behaviour for one edge with the currently driven inputs.
    task automatic cycle();
        exp_t e;
        if (rst || flush) begin
            m_st  = '0;
            m_cnt = 8'd0;
        end else if (freeze) begin
            if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        end else begin
            m_st  = din;
            m_cnt = 8'd0;
            if (!din.valid || (din.mem_r_en && din.mem_w_en)) begin
                m_st.valid = 1'b0; m_st.mem_r_en = 1'b0; m_st.mem_w_en = 1'b0;
                m_st.wb_en = 1'b0; m_st.b = 1'b0; m_st.s = 1'b0;
            end
        end
        e.st  = m_st;
        e.cnt = m_cnt;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic randomize_din();
        din = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic clear_ctrl();
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
    endtask

    initial begin
        m_st = '0; m_cnt = 8'd0;
        clear_ctrl();
        din = '0;
        @(negedge clk);

        // Reset with random inputs for two edges
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            randomize_din();
            freeze = i[0]; flush = ~i[0];
            cycle();
        end
        clear_ctrl();

        // Pass-through vector
        din = '0;
        din.pc = 32'h10; din.val_rm = 32'h8000_0001; din.shift_operand = 12'h0E3;
        din.imm = 1'b1; din.exe_cmd = 4'b0010; din.wb_en = 1'b1; din.valid = 1'b1;
        cycle();

        // Full-field load, then same data with valid_in low
        din = '{valid:1'b1, pc:32'hDEAD_BEEF, val_rn:32'h1234_5678, val_rm:32'hCAFE_F00D,
                shift_operand:12'hA5A, imm:1'b0, signed_imm:24'hFF_FFFE, dest:4'hE,
                src1:4'h3, src2:4'hC, exe_cmd:4'h9, mem_r_en:1'b1, mem_w_en:1'b0,
                wb_en:1'b1, b:1'b1, s:1'b1, status:4'hA};
        cycle();
        din.valid = 1'b0;
        cycle();

        // Freeze: load 0x20, hold for three edges while 0x24 waits, then release
        din = '0; din.valid = 1'b1; din.wb_en = 1'b1; din.pc = 32'h20;
        cycle();
        din.pc = 32'h24;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        freeze = 1'b0;
        cycle();

        // Flush together with freeze gives a bubble
        din.wb_en = 1'b1; din.mem_w_en = 1'b1; din.pc = 32'h28;
        freeze = 1'b1; flush = 1'b1;
        cycle();
        clear_ctrl();

        // Illegal read+write request
        din = '0; din.valid = 1'b1; din.mem_r_en = 1'b1; din.mem_w_en = 1'b1;
        din.pc = 32'h30; din.val_rn = 32'h55; din.dest = 4'h7; din.wb_en = 1'b1;
        cycle();

        // Long freeze to saturation, then release
        din.mem_r_en = 1'b0; din.pc = 32'h34;
        cycle();
        freeze = 1'b1;
        for (int i = 0; i < 300; i++) cycle();
        freeze = 1'b0;
        cycle();

        // Reset asserted mid-freeze, then normal priority resumes
        din.pc = 32'h40; cycle();
        freeze = 1'b1; cycle(); cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        freeze = 1'b0; cycle();

        // A few random loads and flushes
        for (int i = 0; i < 8; i++) begin
            randomize_din();
            flush  = (i == 5);
            freeze = (i == 3);
            cycle();
        end
        clear_ctrl();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain got=%0d pending exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_exe_stage_reg.md
ID_EXE_STAGE_REG -- requirements
Module: id_exe_stage_reg

Interface
REQ-001: Parameter WORD_WIDTH, default 32, datapath word width.
REQ-002: clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: freeze  input  1  hazard stall; hold all registered outputs.
REQ-005: flush  input  1  taken branch; insert bubble.
REQ-006: valid_in / valid_out  1  instruction-present flag.
REQ-007: pc_in / pc_out  WORD_WIDTH  instruction PC+4.
REQ-008: val_rn_in / val_rn_out  WORD_WIDTH  first operand value.
REQ-009: val_rm_in / val_rm_out  WORD_WIDTH  raw Rm value fed to the Val2 generator.
REQ-010: shift_operand_in / shift_operand_out  12  shifter operand field.
REQ-011: imm_in / imm_out  1  immediate-operand flag (I bit).
REQ-012: signed_imm_in / signed_imm_out  24  branch offset.
REQ-013: dest_in / dest_out, src1_in / src1_out, src2_in / src2_out  4 each  register addresses for writeback and forwarding.
REQ-014: exe_cmd_in / exe_cmd_out  4  ALU command.
REQ-015: mem_r_en, mem_w_en, wb_en, b, s  (_in / _out)  1 each  memory-read, memory-write, writeback, branch, and set-flags controls.
REQ-016: status_in / status_out  4  NZCV flags captured with the instruction.
REQ-017: stall_cnt  output  8  count of consecutive frozen cycles.

Function
REQ-018: Per-edge priority SHALL be rst > flush > freeze > load.
REQ-019: Load (no rst/flush/freeze): every _out SHALL take its _in value at the edge, giving 1-cycle latency.
REQ-020: Load with valid_in=0: data fields SHALL be captured, but wb_en, mem_r_en, mem_w_en, b, s, and valid_out SHALL be forced to 0.
REQ-021: Flush: all _out registers SHALL be cleared to 0, producing a bubble.
REQ-022: Freeze (no flush): all _out registers SHALL hold their previous values.
REQ-023: Flush and freeze asserted together: flush SHALL win, producing a bubble rather than a hold.
REQ-024: mem_r_en_out and mem_w_en_out SHALL never both be 1; if both inputs are 1, the edge SHALL be treated as a bubble per REQ-020.
REQ-025: stall_cnt SHALL increment on each edge with freeze=1 and flush=0.
REQ-026: stall_cnt SHALL saturate at 255 and never wrap.
REQ-027: stall_cnt SHALL clear to 0 on any edge with freeze=0 or flush=1.
REQ-028: The block SHALL be purely registered: no combinational path from any input to any output.
REQ-029: Field widths SHALL pass through unchanged; no sign extension or shifting in this block (Val2 generation is downstream).

Reset
REQ-030: On an edge with rst=1, every output, including stall_cnt, SHALL become 0, regardless of flush, freeze, or valid_in.
REQ-031: Reset asserted mid-freeze SHALL clear held state; the first edge after rst deasserts SHALL follow normal priority.
REQ-032: All outputs SHALL be 0 from the first edge with rst=1 until the first load.

Verification
REQ-033: Reset: apply rst=1 for 2 cycles with random inputs -> all outputs 0, stall_cnt=0.
REQ-034: Pass-through: pc_in=0x10, val_rm_in=0x8000_0001, shift_operand_in=0x0E3, imm_in=1, exe_cmd_in=4'b0010, wb_en_in=1, valid_in=1 -> identical values on the outputs one edge later.
REQ-035: Freeze: load pc_in=0x20, then freeze=1 for 3 cycles with pc_in=0x24 -> pc_out stays 0x20 and stall_cnt reads 1, 2, 3; on release, pc_out=0x24 and stall_cnt=0.
REQ-036: Flush with freeze: flush=1 and freeze=1 with wb_en_in=1, mem_w_en_in=1 -> next edge gives all outputs 0 and stall_cnt=0.
REQ-037: Saturation: freeze=1 for 300 cycles -> stall_cnt reaches 255 and holds at 255.
REQ-038: Illegal controls: mem_r_en_in=1, mem_w_en_in=1, valid_in=1 -> both enables 0, valid_out=0, data fields captured.
